// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field positions, mesh size, the NI state
// encoding and the helper that assembles an XY-offset flit.
// No ports (package).
package noc_pkg;

    localparam int FLIT_W   = 64;
    localparam int XOFF_MSB = 55;
    localparam int XOFF_LSB = 52;
    localparam int YOFF_MSB = 51;
    localparam int YOFF_LSB = 48;
    localparam int TAG_W    = 32;
    localparam int MESH_DIM = 4;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ni_state_e;

    // Flit layout: [63:56] zero, [55:52] x_off, [51:48] y_off, [47:32] zero, [31:0] tag.
    function automatic logic [FLIT_W-1:0] mk_xy_flit(input logic [3:0]       x_off,
                                                     input logic [3:0]       y_off,
                                                     input logic [TAG_W-1:0] tag);
        logic [FLIT_W-1:0] f;
        f                     = '0;
        f[XOFF_MSB:XOFF_LSB]  = x_off;
        f[YOFF_MSB:YOFF_LSB]  = y_off;
        f[TAG_W-1:0]          = tag;
        return f;
    endfunction

endpackage

// File: rtl/noc_ni_scheduler_if.sv
// Bundle of the NI's handshake buses: the requester side (req_*), the
// router injection port (pesi/pedi/peri), the router ejection port
// (peso/pedo/pero) and the local consumer side (ej_*).
// Modports:
//   master - the environment: drives requests, router responses and ej_ready
//   slave  - the network interface itself
interface noc_ni_scheduler_if
    import noc_pkg::*;
#(
    parameter int NREQ = 4
) ();

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_dst_row;
    logic [2*NREQ-1:0]     req_dst_col;
    logic [TAG_W*NREQ-1:0] req_tag;

    logic                  pesi;
    logic [FLIT_W-1:0]     pedi;
    logic                  peri;

    logic                  peso;
    logic [FLIT_W-1:0]     pedo;
    logic                  pero;

    logic                  ej_valid;
    logic [TAG_W-1:0]      ej_tag;
    logic                  ej_ready;

    modport master (
        output req_valid, req_dst_row, req_dst_col, req_tag,
        input  req_ready,
        input  pesi, pedi,
        output peri,
        output peso, pedo,
        input  pero,
        input  ej_valid, ej_tag,
        output ej_ready
    );

    modport slave (
        input  req_valid, req_dst_row, req_dst_col, req_tag,
        output req_ready,
        output pesi, pedi,
        input  peri,
        input  peso, pedo,
        output pero,
        output ej_valid, ej_tag,
        input  ej_ready
    );

endinterface

// File: rtl/noc_ni_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, searching cyclically.
// Ports:
//   req   in  NREQ   request vector
//   ptr   in  PTR_W  highest-priority index
//   grant out NREQ   one-hot grant, zero when no request
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_ni_scheduler.sv
// Network interface between NREQ local requesters and a router's PE port.
// Round-robin picks a requester, turns its (row, col) destination into an
// XY-offset flit and injects it; a one-entry buffer holds ejected flits for
// the local consumer. Keeps tx/rx counters and sticky error flags.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   bus (slave)     req_*, pesi/pedi/peri, peso/pedo/pero, ej_*
//   tx_count        injected flits (wrapping)
//   rx_count        ejected flits (wrapping)
//   stall_err       sticky: pesi waited STALL_LIMIT cycles for peri
//   misroute_err    sticky: an ejected flit carried nonzero offsets
module noc_ni_scheduler
    import noc_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int MY_ROW      = 0,
    parameter int MY_COL      = 0,
    parameter int STALL_LIMIT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    noc_ni_scheduler_if.slave     bus,
    output logic [15:0]           tx_count,
    output logic [15:0]           rx_count,
    output logic                  stall_err,
    output logic                  misroute_err
);

    localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    ni_state_e        state, state_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [PTR_W-1:0] sel_idx;
    logic [1:0]       sel_row, sel_col;
    logic [TAG_W-1:0] sel_tag;
    logic [3:0]       x_off, y_off;
    logic             take, xfer;
    logic [STALL_W-1:0] stall_cnt;
    logic             ej_take, ej_drain;
    logic             unused_pedo_bits;

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Route the granted requester's destination and tag.
    always_comb begin
        sel_idx = '0;
        sel_row = '0;
        sel_col = '0;
        sel_tag = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel_idx = PTR_W'(k);
                sel_row = bus.req_dst_row[2*k +: 2];
                sel_col = bus.req_dst_col[2*k +: 2];
                sel_tag = bus.req_tag[TAG_W*k +: TAG_W];
            end
        end
    end

    // Mod-16 offsets; y grows downward so a larger destination row gives a negative y_off.
    assign x_off = {2'b00, sel_col} - 4'(MY_COL);
    assign y_off = 4'(MY_ROW) - {2'b00, sel_row};

    assign take = (state == S_IDLE) && |(bus.req_valid & grant);
    assign xfer = (state == S_SEND) && bus.peri;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // req_ready is masked during reset so every handshake output reads zero then.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.pesi      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!reset) bus.req_ready = grant;
                if (|(bus.req_valid & grant)) state_nxt = S_SEND;
            end
            S_SEND: begin
                bus.pesi = 1'b1;
                if (bus.peri) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pedi <= '0;
            rr_ptr   <= '0;
        end else if (take) begin
            bus.pedi <= mk_xy_flit(x_off, y_off, sel_tag);
            rr_ptr   <= (sel_idx == PTR_W'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
        end
    end

    // Stall counter saturates at STALL_LIMIT; the flag is raised on the edge it gets there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_count  <= '0;
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (xfer) begin
            tx_count  <= tx_count + 16'd1;
            stall_cnt <= '0;
        end else if (state == S_SEND) begin
            if (stall_cnt != STALL_W'(STALL_LIMIT)) stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == STALL_W'(STALL_LIMIT - 1)) stall_err <= 1'b1;
        end
    end

    // One-entry ejection buffer with no bypass: pero only reopens after the drain edge.
    assign bus.pero  = !bus.ej_valid;
    assign ej_take   = bus.peso && !bus.ej_valid;
    assign ej_drain  = bus.ej_valid && bus.ej_ready;
    assign unused_pedo_bits = ^{bus.pedo[63:56], bus.pedo[47:32]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ej_valid <= 1'b0;
            bus.ej_tag   <= '0;
            rx_count     <= '0;
            misroute_err <= 1'b0;
        end else if (ej_take) begin
            bus.ej_valid <= 1'b1;
            bus.ej_tag   <= bus.pedo[TAG_W-1:0];
            rx_count     <= rx_count + 16'd1;
            if (bus.pedo[XOFF_MSB:YOFF_LSB] != 8'h00) misroute_err <= 1'b1;
        end else if (ej_drain) begin
            bus.ej_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noc_ni_scheduler.sv
// Scoreboard bench for noc_ni_scheduler at node (row 2, col 1).
// A reference model tracks the NI at transaction level and pushes expected
// flits/tags into queues; a monitor compares DUT outputs on the falling edge.
module tb_noc_ni_scheduler;

    localparam int NREQ        = 4;
    localparam int MY_ROW      = 2;
    localparam int MY_COL      = 1;
    localparam int STALL_LIMIT = 64;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        probe = 1'b0;
    logic [15:0] tx_count, rx_count;
    logic        stall_err, misroute_err;

    noc_ni_scheduler_if #(.NREQ(NREQ)) bus ();

    noc_ni_scheduler #(
        .NREQ        (NREQ),
        .MY_ROW      (MY_ROW),
        .MY_COL      (MY_COL),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .tx_count     (tx_count),
        .rx_count     (rx_count),
        .stall_err    (stall_err),
        .misroute_err (misroute_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    int  m_ptr    = 0;
    bit  m_busy   = 1'b0;
    int  m_stall  = 0;
    bit  m_serr   = 1'b0;
    bit  m_merr   = 1'b0;
    bit  m_ejfull = 1'b0;
    int  m_tx     = 0;
    int  m_rx     = 0;
    int  last_win = -1;
    logic [63:0] exp_tx[$];
    logic [31:0] exp_ej[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] exp_flit(input int r, input int c, input logic [31:0] tag);
        logic [3:0] xo, yo;
        xo = 4'((c - MY_COL + 16) % 16);
        yo = 4'((MY_ROW - r + 16) % 16);
        return {8'h00, xo, yo, 16'h0000, tag};
    endfunction

    // Reference model: one step per clock edge, asynchronously cleared by reset.
    initial begin
        int w;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_ptr = 0; m_busy = 1'b0; m_stall = 0; m_serr = 1'b0; m_merr = 1'b0;
                m_ejfull = 1'b0; m_tx = 0; m_rx = 0; last_win = -1;
                exp_tx.delete();
                exp_ej.delete();
            end else begin
                last_win = -1;
                if (m_busy) begin
                    if (bus.peri) begin
                        m_busy = 1'b0; m_tx = (m_tx + 1) % 65536; m_stall = 0;
                    end else begin
                        m_stall++;
                        if (m_stall >= STALL_LIMIT) m_serr = 1'b1;
                    end
                end else begin
                    w = pick(bus.req_valid, m_ptr);
                    if (w >= 0) begin
                        exp_tx.push_back(exp_flit(int'(bus.req_dst_row[2*w +: 2]),
                                                  int'(bus.req_dst_col[2*w +: 2]),
                                                  bus.req_tag[32*w +: 32]));
                        m_ptr = (w + 1) % NREQ; m_busy = 1'b1; last_win = w;
                    end
                end
                if (!m_ejfull && bus.peso) begin
                    exp_ej.push_back(bus.pedo[31:0]);
                    m_ejfull = 1'b1; m_rx = (m_rx + 1) % 65536;
                    if (bus.pedo[55:48] != 8'h00) m_merr = 1'b1;
                end else if (m_ejfull && bus.ej_ready) begin
                    m_ejfull = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: the only process that compares.
    initial begin
        forever begin
            @(negedge clk or posedge probe);
            if (reset) begin
                chk("rst_pesi",      64'(bus.pesi),      64'(0));
                chk("rst_pedi",      64'(bus.pedi),      64'(0));
                chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
                chk("rst_ej_valid",  64'(bus.ej_valid),  64'(0));
                chk("rst_ej_tag",    64'(bus.ej_tag),    64'(0));
                chk("rst_tx_count",  64'(tx_count),      64'(0));
                chk("rst_rx_count",  64'(rx_count),      64'(0));
                chk("rst_stall_err", 64'(stall_err),     64'(0));
                chk("rst_misroute",  64'(misroute_err),  64'(0));
            end else begin
                chk("pesi", 64'(bus.pesi), 64'(m_busy));
                chk("req_ready", 64'(bus.req_ready),
                    64'(m_busy ? '0 : onehot(pick(bus.req_valid, m_ptr))));
                if (bus.pesi) begin
                    if (exp_tx.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL pedi: flit %h presented, none expected at %0t", bus.pedi, $time);
                    end else begin
                        chk("pedi", bus.pedi, exp_tx[0]);
                        if (bus.peri) void'(exp_tx.pop_front());
                    end
                end
                chk("ej_valid", 64'(bus.ej_valid), 64'(m_ejfull));
                chk("pero",     64'(bus.pero),     64'(!m_ejfull));
                if (bus.ej_valid) begin
                    if (exp_ej.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL ej_tag: tag %h presented, none expected at %0t", bus.ej_tag, $time);
                    end else begin
                        chk("ej_tag", 64'(bus.ej_tag), 64'(exp_ej[0]));
                        if (bus.ej_ready) void'(exp_ej.pop_front());
                    end
                end
                chk("tx_count",     64'(tx_count),     64'(m_tx));
                chk("rx_count",     64'(rx_count),     64'(m_rx));
                chk("stall_err",    64'(stall_err),    64'(m_serr));
                chk("misroute_err", 64'(misroute_err), 64'(m_merr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int r, input int c, input logic [31:0] tag);
        bus.req_valid[k]          = 1'b1;
        bus.req_dst_row[2*k +: 2] = 2'(r);
        bus.req_dst_col[2*k +: 2] = 2'(c);
        bus.req_tag[32*k +: 32]   = tag;
    endtask

    task automatic rand_req(input int k);
        set_req(k, $urandom_range(0, 3), $urandom_range(0, 3), 32'($urandom));
    endtask

    task automatic drop_granted();
        if (last_win >= 0) bus.req_valid[last_win] = 1'b0;
    endtask

    initial begin
        bus.req_valid = '0; bus.req_dst_row = '0; bus.req_dst_col = '0; bus.req_tag = '0;
        bus.peri = 1'b0; bus.peso = 1'b0; bus.pedo = '0; bus.ej_ready = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Directed destinations: (3,3) -> x=2,y=F; loopback (2,1); (0,0) -> x=F,y=2
        set_req(0, 3, 3, 32'hA000_0001);
        set_req(1, 2, 1, 32'hB000_0009);
        set_req(2, 0, 0, 32'hC000_0003);
        bus.peri = 1'b1;
        repeat (10) begin tick(); drop_granted(); end

        // All requesters continuously valid, router always ready
        for (int k = 0; k < NREQ; k++) rand_req(k);
        repeat (20) begin tick(); if (last_win >= 0) rand_req(last_win); end
        bus.req_valid = '0;
        repeat (4) tick();

        // Router stalls for 70 cycles with a flit pending
        rand_req(3);
        bus.peri = 1'b0;
        tick(); drop_granted();
        repeat (70) tick();
        bus.peri = 1'b1;
        repeat (3) tick();

        // Ejection buffering, back-pressure, misroute
        bus.peso = 1'b1; bus.pedo = 64'h0000_0000_C000_0005;
        tick();
        bus.pedo = 64'h0000_0000_D000_0006;
        repeat (4) tick();
        bus.ej_ready = 1'b1; tick(); bus.ej_ready = 1'b0;
        tick();
        bus.peso = 1'b0; bus.ej_ready = 1'b1; tick(); bus.ej_ready = 1'b0;
        bus.pedo = {8'h00, 8'h10, 16'h0000, 32'hE000_0007}; bus.peso = 1'b1;
        tick();
        bus.peso = 1'b0; bus.ej_ready = 1'b1;
        repeat (2) tick();
        bus.ej_ready = 1'b0;

        // Randomized mixed traffic
        repeat (3000) begin
            tick();
            for (int k = 0; k < NREQ; k++) begin
                if (k == last_win || !bus.req_valid[k]) begin
                    if ($urandom_range(0, 1) == 1) rand_req(k);
                    else bus.req_valid[k] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req_valid[k] = 1'b0;
                end
            end
            bus.peri     = ($urandom_range(0, 3) != 0);
            bus.peso     = 1'($urandom_range(0, 1));
            bus.pedo     = {8'h00, ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00,
                            16'h0000, 32'($urandom)};
            bus.ej_ready = 1'($urandom_range(0, 1));
        end

        // Reset in the middle of SEND with a buffered ejected flit
        bus.req_valid = '0; bus.peso = 1'b0; bus.ej_ready = 1'b0; bus.peri = 1'b1;
        repeat (3) tick();
        rand_req(0);
        bus.peri = 1'b0; bus.peso = 1'b1; bus.pedo = 64'h0000_0000_F000_000F;
        tick(); drop_granted();
        bus.peso = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        bus.peri = 1'b1;
        rand_req(2);
        tick(); drop_granted();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
